// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and constants for the universal shift register sequencer
package usr_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR     = 2'b00,
    OP_LOAD      = 2'b01,
    OP_SHIFT_IN  = 2'b10,
    OP_SHIFT_OUT = 2'b11
  } op_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_SHIN,
    S_SHOUT_LD,
    S_SHOUT
  } state_t;

  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_LEFT : SEL_RIGHT;
  endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// rtl/usr_shift_cnt.sv - loadable down-counter tracking remaining shift beats
module usr_shift_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          is_one
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/usr_seq.sv
// rtl/usr_seq.sv - command sequencer driving the universal shift register pins
module usr_seq
  import usr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CW-1:0]    cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             sin_data,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_data,
  output logic             done,
  output logic             busy,
  output logic [1:0]       usr_sel,
  output logic             usr_si,
  output logic [WIDTH-1:0] usr_pi,
  output logic             usr_clr,
  input  logic [WIDTH-1:0] usr_po
);

  state_t           state;
  logic             dir_q;
  logic [CW-1:0]    len_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    len_clamped;
  logic             cnt_is_one;
  logic             hs;
  logic             sin_xfer;
  logic             sout_xfer;
  logic [WIDTH-1:0] out_pick;

  assign len_clamped = (cmd_len > CW'(WIDTH)) ? CW'(WIDTH) : cmd_len;
  assign cmd_ready   = clr_n && (state == S_IDLE);
  assign hs          = cmd_valid && cmd_ready;
  assign sin_xfer    = (state == S_SHIN) && sin_valid;
  assign sout_xfer   = (state == S_SHOUT) && sout_ready;
  assign busy        = (state != S_IDLE);

  usr_shift_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (hs),
    .load_val (len_clamped),
    .dec      (sin_xfer || sout_xfer),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= S_IDLE;
      dir_q  <= 1'b0;
      len_q  <= '0;
      data_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            dir_q  <= cmd_dir;
            len_q  <= len_clamped;
            data_q <= cmd_data;
            case (cmd_op)
              OP_CLEAR:    state <= S_CLR;
              OP_LOAD:     state <= S_LOAD;
              OP_SHIFT_IN: begin
                if (len_clamped == '0) done <= 1'b1;
                else                   state <= S_SHIN;
              end
              default:     state <= S_SHOUT_LD;
            endcase
          end
        end
        S_CLR, S_LOAD: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        S_SHIN: begin
          if (sin_valid && cnt_is_one) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_SHOUT_LD: begin
          if (len_q == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= S_SHOUT;
          end
        end
        S_SHOUT: begin
          if (sout_ready && cnt_is_one) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outgoing bit is the end that falls off next: MSB for left, LSB for right.
  assign out_pick = dir_q ? (WIDTH'(1) << (WIDTH - 1)) : WIDTH'(1);

  always_comb begin
    usr_sel    = SEL_HOLD;
    usr_si     = 1'b0;
    usr_pi     = '0;
    usr_clr    = 1'b0;
    sin_ready  = 1'b0;
    sout_valid = 1'b0;
    sout_data  = 1'b0;
    if (!clr_n) begin
      usr_clr = 1'b1;
    end else begin
      case (state)
        S_CLR: usr_clr = 1'b1;
        S_LOAD, S_SHOUT_LD: begin
          usr_sel = SEL_LOAD;
          usr_pi  = data_q;
        end
        S_SHIN: begin
          sin_ready = 1'b1;
          if (sin_valid) begin
            usr_sel = shift_sel(dir_q);
            usr_si  = sin_data;
          end
        end
        S_SHOUT: begin
          sout_valid = 1'b1;
          sout_data  = |(usr_po & out_pick);
          if (sout_ready) usr_sel = shift_sel(dir_q);
        end
        default: ;
      endcase
    end
  end

endmodule
